// File: rtl/abies_i2s_pkg.sv
// Shared types and parameter checks for the I2S master transmitter.
//   i2s_state_t : link run state (IDLE = stopped, RUN = clocking frames)
//   slot_ok     : true when a channel slot can hold the delay bit plus DW data bits
package abies_i2s_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } i2s_state_t;

  function automatic bit slot_ok(input int unsigned dw, input int unsigned slot);
    return slot >= dw + 1;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit-clock generator and run/stop control.
//   clk, rst  : system clock, asynchronous active-low reset
//   en        : run enable; starts the link from IDLE, stops it only at a frame end
//   last_bit  : serializer is on the final bit of the frame
//   sclk      : registered I2S bit clock
//   fall      : one-clk strobe on the edge where sclk goes 1 -> 0
//   stop      : one-clk strobe on the frame-end fall where the link returns to IDLE
module i2s_clkgen
  import abies_i2s_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic last_bit,
  output logic sclk,
  output logic fall,
  output logic stop
);

  localparam int unsigned DCW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DCW-1:0] DIV_MAX = DCW'(SCLK_DIV - 1);

  i2s_state_t     state_q, state_d;
  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic           sclk_q, sclk_d;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    fall      = 1'b0;
    stop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (div_cnt_q == DIV_MAX) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          fall      = sclk_q;
        end else begin
          div_cnt_d = div_cnt_q + DCW'(1);
        end
        // en is only honoured at the frame boundary; sclk is already heading low here
        if (fall && last_bit && !en) begin
          stop      = 1'b1;
          state_d   = IDLE;
          div_cnt_d = '0;
          sclk_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: generates sclk/lrclk and serializes one stereo frame
// at a time from two single-entry holding registers onto sdo.
//   clk, rst           : system clock, asynchronous active-low reset
//   en                 : run enable, sampled at frame boundaries
//   l_valid/l_data/l_ready : left sample handshake (ready = holding register empty)
//   r_valid/r_data/r_ready : right sample handshake
//   sclk, lrclk, sdo   : I2S link (lrclk 0 = left slot), one-bit-delayed MSB-first data
//   underrun           : one-clk pulse when a channel was empty at frame load
module i2s_tx_master
  import abies_i2s_pkg::*;
#(
  parameter int unsigned DW       = 24,
  parameter int unsigned SLOT     = 32,
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          l_valid,
  input  logic [DW-1:0] l_data,
  output logic          l_ready,
  input  logic          r_valid,
  input  logic [DW-1:0] r_data,
  output logic          r_ready,
  output logic          sclk,
  output logic          lrclk,
  output logic          sdo,
  output logic          underrun
);

  if (!slot_ok(DW, SLOT) || SCLK_DIV < 1) begin : g_bad_params
    $error("i2s_tx_master: need SLOT >= DW+1 and SCLK_DIV >= 1");
  end

  localparam int unsigned BCW = $clog2(2 * SLOT);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(2 * SLOT - 1);

  logic           fall, stop, last_bit, load;
  logic           l_full_q, l_full_d, r_full_q, r_full_d;
  logic [DW-1:0]  l_hold_q, l_hold_d, r_hold_q, r_hold_d;
  logic [DW-1:0]  l_frame_q, l_frame_d, r_frame_q, r_frame_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           lrclk_q, lrclk_d, sdo_q, sdo_d, underrun_q, underrun_d;

  i2s_clkgen #(.SCLK_DIV(SCLK_DIV)) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .last_bit (last_bit),
    .sclk     (sclk),
    .fall     (fall),
    .stop     (stop)
  );

  assign last_bit = (bit_cnt_q == LAST_BIT);
  assign load     = fall && last_bit && !stop;

  always_comb begin
    int unsigned   bc;
    int unsigned   b;
    logic [DW-1:0] sel;
    bc         = 0;
    b          = 0;
    sel        = '0;
    l_full_d   = l_full_q;
    r_full_d   = r_full_q;
    l_hold_d   = l_hold_q;
    r_hold_d   = r_hold_q;
    l_frame_d  = l_frame_q;
    r_frame_d  = r_frame_q;
    bit_cnt_d  = bit_cnt_q;
    lrclk_d    = lrclk_q;
    sdo_d      = sdo_q;
    underrun_d = 1'b0;

    // Load drains only registers that were full before this edge, so a sample
    // accepted on the load edge itself stays queued for the following frame.
    if (load) begin
      l_frame_d  = l_full_q ? l_hold_q : '0;
      r_frame_d  = r_full_q ? r_hold_q : '0;
      l_full_d   = 1'b0;
      r_full_d   = 1'b0;
      underrun_d = !l_full_q || !r_full_q;
    end
    if (l_valid && !l_full_q) begin
      l_full_d = 1'b1;
      l_hold_d = l_data;
    end
    if (r_valid && !r_full_q) begin
      r_full_d = 1'b1;
      r_hold_d = r_data;
    end

    if (stop) begin
      bit_cnt_d = LAST_BIT;
      lrclk_d   = 1'b1;
      sdo_d     = 1'b0;
    end else if (fall) begin
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + BCW'(1);
      bc        = 32'(bit_cnt_d);
      lrclk_d   = (bc >= SLOT);
      b         = bc % SLOT;
      sdo_d     = 1'b0;
      if (b >= 1 && b <= DW) begin
        sel   = ((bc >= SLOT) ? r_frame_d : l_frame_d) >> (DW - b);
        sdo_d = sel[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_full_q   <= 1'b0;
      r_full_q   <= 1'b0;
      l_hold_q   <= '0;
      r_hold_q   <= '0;
      l_frame_q  <= '0;
      r_frame_q  <= '0;
      bit_cnt_q  <= LAST_BIT;
      lrclk_q    <= 1'b1;
      sdo_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      l_full_q   <= l_full_d;
      r_full_q   <= r_full_d;
      l_hold_q   <= l_hold_d;
      r_hold_q   <= r_hold_d;
      l_frame_q  <= l_frame_d;
      r_frame_q  <= r_frame_d;
      bit_cnt_q  <= bit_cnt_d;
      lrclk_q    <= lrclk_d;
      sdo_q      <= sdo_d;
      underrun_q <= underrun_d;
    end
  end

  assign l_ready  = !l_full_q;
  assign r_ready  = !r_full_q;
  assign lrclk    = lrclk_q;
  assign sdo      = sdo_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: an I2S receiver model captures 32-bit slots on sclk
// rising edges and compares them with expected slot words queued at stimulus time.
module tb_i2s_tx_master;

  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          l_valid = 1'b0, r_valid = 1'b0;
  logic [DW-1:0] l_data = '0, r_data = '0;
  logic          l_ready, r_ready, sclk, lrclk, sdo, underrun;

  i2s_tx_master #(.DW(24), .SLOT(32), .SCLK_DIV(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .l_valid  (l_valid),
    .l_data   (l_data),
    .l_ready  (l_ready),
    .r_valid  (r_valid),
    .r_data   (r_data),
    .r_ready  (r_ready),
    .sclk     (sclk),
    .lrclk    (lrclk),
    .sdo      (sdo),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected slot word: {channel, delay bit, data, 7 trailing zeros}
  logic [32:0] exp_q[$];

  function automatic logic [32:0] slot_word(input logic ch, input logic [DW-1:0] d);
    return {ch, 1'b0, d, 7'b0};
  endfunction

  // receiver / monitor state
  logic        prev_sclk = 1'b0, prev_lr = 1'b1, prev_ur = 1'b0;
  logic [31:0] sh = '0;
  int          bcnt = 0;
  int          ur_cnt = 0, ur_wide = 0, sclk_rises = 0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_sclk = 1'b0;
      prev_lr   = 1'b1;
      bcnt      = 0;
      sh        = '0;
    end else begin
      if (sclk && !prev_sclk) begin
        sclk_rises++;
        if (lrclk != prev_lr) bcnt = 0;
        prev_lr = lrclk;
        sh      = {sh[30:0], sdo};
        bcnt++;
        if (bcnt == 32) begin
          if (exp_q.size() == 0) check_eq("slot_unexpected", {prev_lr, sh}, 33'h1_FFFF_FFFF);
          else check_eq("slot", {prev_lr, sh}, exp_q.pop_front());
          bcnt = 0;
        end
      end
      prev_sclk = sclk;
    end
    if (underrun) begin
      ur_cnt++;
      if (prev_ur) ur_wide++;
    end
    prev_ur = underrun;
  end

  task automatic send_l(input logic [DW-1:0] d);
    @(negedge clk);
    check_eq("l_ready_pre", l_ready, 1);
    l_valid = 1'b1;
    l_data  = d;
    @(posedge clk);
    #1 l_valid = 1'b0;
  endtask

  task automatic send_r(input logic [DW-1:0] d);
    @(negedge clk);
    check_eq("r_ready_pre", r_ready, 1);
    r_valid = 1'b1;
    r_data  = d;
    @(posedge clk);
    #1 r_valid = 1'b0;
  endtask

  task automatic wait_l_load(input int max);
    for (int i = 0; i < max && !l_ready; i++) @(negedge clk);
    check_eq("l_load", l_ready, 1);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() > 0; i++) @(negedge clk);
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    int r0;
    r0 = sclk_rises;
    repeat (40) @(negedge clk);
    check_eq({tag, "_sclk"}, sclk, 0);
    check_eq({tag, "_lrclk"}, lrclk, 1);
    check_eq({tag, "_sdo"}, sdo, 0);
    check_eq({tag, "_rises"}, sclk_rises - r0, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ur0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // idle after reset, no enable
    repeat (200) @(negedge clk);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_lrclk", lrclk, 1);
    check_eq("rst_sdo", sdo, 0);
    check_eq("rst_l_ready", l_ready, 1);
    check_eq("rst_r_ready", r_ready, 1);
    check_eq("rst_ur_cnt", ur_cnt, 0);
    check_eq("rst_rises", sclk_rises, 0);

    // full stereo frame, en dropped mid-left-slot
    send_l(24'hA5A5A5);
    send_r(24'h123456);
    @(negedge clk);
    check_eq("l_held", l_ready, 0);
    check_eq("r_held", r_ready, 0);
    exp_q.push_back(slot_word(1'b0, 24'hA5A5A5));
    exp_q.push_back(slot_word(1'b1, 24'h123456));
    ur0 = ur_cnt;
    en = 1'b1;
    wait_l_load(50);
    check_eq("r_load", r_ready, 1);
    repeat (40) @(negedge clk);
    en = 1'b0;
    wait_drain(700);
    check_eq("stereo_ur", ur_cnt - ur0, 0);
    check_idle("stop1");

    // left only: right slot zero, one underrun
    send_l(24'h7FFFFF);
    ur0 = ur_cnt;
    exp_q.push_back(slot_word(1'b0, 24'h7FFFFF));
    exp_q.push_back(slot_word(1'b1, 24'h0));
    @(negedge clk);
    en = 1'b1;
    wait_l_load(50);
    repeat (40) @(negedge clk);
    en = 1'b0;
    wait_drain(700);
    check_eq("lonly_ur", ur_cnt - ur0, 1);
    check_idle("stop2");

    // sample accepted on the load edge goes to the next frame
    ur0 = ur_cnt;
    exp_q.push_back(slot_word(1'b0, 24'h0));
    exp_q.push_back(slot_word(1'b1, 24'h0));
    exp_q.push_back(slot_word(1'b0, 24'h5A0F33));
    exp_q.push_back(slot_word(1'b1, 24'h0));
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    l_valid = 1'b1;
    l_data  = 24'h5A0F33;
    @(posedge clk);
    #1 l_valid = 1'b0;
    check_eq("same_edge_held", l_ready, 0);
    wait_l_load(400);
    repeat (40) @(negedge clk);
    en = 1'b0;
    wait_drain(900);
    check_eq("same_edge_ur", ur_cnt - ur0, 2);
    check_idle("stop3");

    // reset mid-frame discards everything
    send_l(24'h111111);
    send_r(24'h222222);
    @(negedge clk);
    en = 1'b1;
    repeat (60) @(negedge clk);
    send_l(24'h333333);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_sclk", sclk, 0);
    check_eq("mid_rst_lrclk", lrclk, 1);
    check_eq("mid_rst_sdo", sdo, 0);
    check_eq("mid_rst_underrun", underrun, 0);
    check_eq("mid_rst_l_ready", l_ready, 1);
    check_eq("mid_rst_r_ready", r_ready, 1);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_idle("post_rst");

    // after reset nothing held: an empty frame with underrun
    ur0 = ur_cnt;
    exp_q.push_back(slot_word(1'b0, 24'h0));
    exp_q.push_back(slot_word(1'b1, 24'h0));
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 50 && ur_cnt == ur0; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    en = 1'b0;
    wait_drain(700);
    check_eq("post_rst_ur", ur_cnt - ur0, 1);
    check_idle("stop4");

    check_eq("ur_width", ur_wide, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
